// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART defaults and the TX front-end FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned c_NB_DATA_DEFAULT   = 8;
  localparam int unsigned c_ADDR_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } tx_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count and registered flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA   = c_NB_DATA_DEFAULT,
  parameter int unsigned ADDR_BITS = c_ADDR_BITS_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr,
  input  logic [NB_DATA-1:0]   i_wr_data,
  input  logic                 i_pop,
  output logic [NB_DATA-1:0]   o_rd_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count
);

  localparam logic [ADDR_BITS:0] c_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] c_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [NB_DATA-1:0]   r_mem [c_DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 w_wr_en;
  logic                 w_pop_en;
  logic [ADDR_BITS:0]   w_count_nxt;

  // A write into a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign w_wr_en  = i_wr  & ~r_full;
  assign w_pop_en = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop_en})
      2'b10:   w_count_nxt = r_count + c_ONE;
      2'b01:   w_count_nxt = r_count - c_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule : sync_fifo

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART TX front end feeding tx_mod one byte at a time.
//               Optional sticky overflow flag under UART_TX_FIFO_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA   = c_NB_DATA_DEFAULT,
  parameter int unsigned ADDR_BITS = c_ADDR_BITS_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr,
  input  logic [NB_DATA-1:0]   i_wr_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_busy,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_data,
  input  logic                 i_tx_done_tick,
  output logic                 o_overflow
);

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic               w_pop;
  logic [NB_DATA-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               r_tx_start;
  logic               r_busy;
  logic [NB_DATA-1:0] r_tx_data;

  sync_fifo #(
    .NB_DATA   (NB_DATA),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (o_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_state_nxt = BUSY;
      end
      BUSY: begin
        if (i_tx_done_tick) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == START);
      r_busy     <= (w_state_nxt != IDLE);
      if (w_pop) begin
        r_tx_data <= w_head;
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (i_wr && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_busy     = r_busy;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

endmodule : uart_tx_fifo

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       done;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic c_OVF_EXP = 1'b1;
`else
  localparam logic c_OVF_EXP = 1'b0;
`endif

  uart_tx_fifo #(
    .NB_DATA   (8),
    .ADDR_BITS (4)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_wr           (wr),
    .i_wr_data      (wr_data),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count),
    .o_busy         (busy),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .i_tx_done_tick (done),
    .o_overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse(input string tag, input logic exp_start, input logic [7:0] exp_data);
    done = 1'b1;
    step();
    done = 1'b0;
    check({tag, "_start"}, {31'd0, tx_start}, {31'd0, exp_start});
    if (exp_start) check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp_data});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    check({tag, "_full"},  {31'd0, full},  32'd0);
    check({tag, "_count"}, {27'd0, count}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_data"},  {24'd0, tx_data},  32'd0);
    check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    logic [7:0] sb[$];
    logic       seen;
    int         n_starts;

    rst_n = 1'b0; wr = 1'b0; wr_data = 8'h00; done = 1'b0;
    #12;
    check_reset_values("rst");
    step();
    rst_n = 1'b1;
    step();

    // Single byte: start pulse two edges after the write.
    wr = 1'b1; wr_data = 8'hAA;
    step();
    wr = 1'b0;
    check("t1_empty0", {31'd0, empty}, 32'd0);
    check("t1_count1", {27'd0, count}, 32'd1);
    check("t1_nostart", {31'd0, tx_start}, 32'd0);
    step();
    check("t1_start", {31'd0, tx_start}, 32'd1);
    check("t1_data", {24'd0, tx_data}, 32'hAA);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_empty1", {31'd0, empty}, 32'd1);
    step();
    check("t1_start_low", {31'd0, tx_start}, 32'd0);
    step(); step();
    check("t1_busy_hold", {31'd0, busy}, 32'd1);
    done_pulse("t1_done", 1'b0, 8'h00);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_empty_end", {31'd0, empty}, 32'd1);

    // Three consecutive writes.
    wr = 1'b1; wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    check("t2_start1", {31'd0, tx_start}, 32'd1);
    check("t2_data1", {24'd0, tx_data}, 32'h11);
    wr_data = 8'h33;
    step();
    wr = 1'b0;
    check("t2_peak", {27'd0, count}, 32'd2);
    check("t2_start1_low", {31'd0, tx_start}, 32'd0);
    step();
    done_pulse("t2_b2", 1'b1, 8'h22);
    step();
    done_pulse("t2_b3", 1'b1, 8'h33);
    check("t2_count0", {27'd0, count}, 32'd0);
    step();
    done_pulse("t2_end", 1'b0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | tx_start;
    end
    check("t2_no_extra", {31'd0, seen}, 32'd0);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // Fill to full while tx_mod is stalled.
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; wr_data = 8'(i);
      step();
      if (i == 1) begin
        check("t3_start0", {31'd0, tx_start}, 32'd1);
        check("t3_data0", {24'd0, tx_data}, 32'h00);
      end
    end
    wr = 1'b0;
    check("t3_count15", {27'd0, count}, 32'd15);
    check("t3_notfull", {31'd0, full}, 32'd0);
    wr = 1'b1; wr_data = 8'hFF;
    step();
    check("t3_count16", {27'd0, count}, 32'd16);
    check("t3_full", {31'd0, full}, 32'd1);
    wr_data = 8'hEE;
    step();
    wr = 1'b0;
    check("t3_drop", {27'd0, count}, 32'd16);
    check("t3_ovf", {31'd0, overflow}, {31'd0, c_OVF_EXP});

    // Write and done on the same edge while full.
    wr = 1'b1; wr_data = 8'h77; done = 1'b1;
    step();
    wr = 1'b0; done = 1'b0;
    check("t4_count15", {27'd0, count}, 32'd15);
    check("t4_notfull", {31'd0, full}, 32'd0);
    check("t4_start", {31'd0, tx_start}, 32'd1);
    check("t4_data", {24'd0, tx_data}, 32'h01);
    check("t4_ovf_sticky", {31'd0, overflow}, {31'd0, c_OVF_EXP});
    for (int j = 2; j < 16; j++) begin
      step();
      done_pulse("t4_drain", 1'b1, 8'(j));
    end
    step();
    done_pulse("t4_last", 1'b1, 8'hFF);
    step();
    done_pulse("t4_end", 1'b0, 8'h00);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_empty", {31'd0, empty}, 32'd1);

    // Twenty bytes with interleaved done ticks; pointers wrap.
    n_starts = 0;
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; wr_data = 8'h40 + 8'(i); done = ((i % 3) == 2);
      sb.push_back(wr_data);
      step();
      if (tx_start) begin
        n_starts++;
        check("t5_order", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
    wr = 1'b0; done = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !busy) break;
      step();
      if (tx_start) begin
        n_starts++;
        check("t5_order", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
    done = 1'b0;
    check("t5_nstarts", n_starts, 32'd20);
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("t5_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset in BUSY with five bytes queued.
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h90 + 8'(i);
      step();
    end
    wr = 1'b0;
    step();
    check("t6_count5", {27'd0, count}, 32'd5);
    check("t6_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | tx_start;
    end
    check("t6_no_start", {31'd0, seen}, 32'd0);
    check("t6_empty", {31'd0, empty}, 32'd1);
    wr = 1'b1; wr_data = 8'h5A;
    step();
    wr = 1'b0;
    step();
    check("t6_restart", {31'd0, tx_start}, 32'd1);
    check("t6_restart_data", {24'd0, tx_data}, 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx_fifo

`default_nettype wire
